// File: rtl/sim_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sim_mem_pkg : shared widths, mailbox codes and lane-select type      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package sim_mem_pkg;

  localparam int DATA_W = 32;
  localparam int BYTES  = 4;

  localparam logic [DATA_W-1:0] MBOX_PASS = 32'h0000_0001;
  localparam logic [DATA_W-1:0] MBOX_FAIL = 32'h0000_0BAD;

  typedef logic [BYTES-1:0] byte_sel_t;

  // Word index taken from a byte address; higher bits alias.
  function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sim_data_ram_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sim_data_ram_if : core data-bus request/response and run status      |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
interface sim_data_ram_if;
  import sim_mem_pkg::*;

  logic              ce_i;
  logic              we_i;
  logic [31:0]       addr_i;
  byte_sel_t         sel_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              rvalid_o;
  logic              done_o;
  logic              pass_o;
  logic              timeout_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, rvalid_o, done_o, pass_o, timeout_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, rvalid_o, done_o, pass_o, timeout_o
  );

endinterface
`default_nettype wire

// File: rtl/sim_data_ram_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_rd_pipe : DEPTH-stage read valid/data shift register, sync flush |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module mem_rd_pipe
  import sim_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  // Data stages only load on a valid beat so the output holds between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        if (valid_q[s-1]) begin
          data_q[s] <= data_q[s-1];
        end
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sim_data_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sim_data_ram : byte-lane data RAM, pipelined reads, mailbox, watchdog|
// | Option       : SIM_DATA_RAM_MAILBOX_EN enables the run-control mailbox|
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module sim_data_ram
  import sim_mem_pkg::*;
#(
  parameter int          ADDR_W         = 10,
  parameter int          RD_LATENCY     = 1,
  parameter logic [31:0] MAILBOX_ADDR   = 32'h0000_1FFC,
  parameter int          TIMEOUT_CYCLES = 5000
) (
  input logic            clk,
  input logic            rst_n,
  sim_data_ram_if.slave  bus
);

  localparam int          WORDS   = 1 << ADDR_W;
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [29:0]       word_full;
  logic [ADDR_W-1:0] idx;
  logic              wr_req;
  logic              rd_req;
  logic              mbox_hit;
  logic              mbox_set;
  logic              done_q;
  logic              pass_q;
  logic [31:0]       wd_cnt_q, wd_cnt_d;
  logic              timeout_q, timeout_d;
  logic              unused_addr;

  assign word_full   = word_of(bus.addr_i);
  assign idx         = word_full[ADDR_W-1:0];
  assign wr_req      = bus.ce_i & bus.we_i;
  assign rd_req      = bus.ce_i & ~bus.we_i;
  assign unused_addr = ^{bus.addr_i[1:0], word_full[29:ADDR_W]};

`ifdef SIM_DATA_RAM_MAILBOX_EN
  assign mbox_hit = wr_req && (bus.addr_i == MAILBOX_ADDR) && (bus.sel_i == 4'hF);

  // Status latches on the first mailbox write only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (mbox_set) begin
      done_q <= 1'b1;
      pass_q <= (bus.data_i == MBOX_PASS);
    end
  end
`else
  localparam logic [31:0] unused_mbox_addr = MAILBOX_ADDR;
  assign mbox_hit = 1'b0;
  assign done_q   = 1'b0;
  assign pass_q   = 1'b0;
`endif

  assign mbox_set = mbox_hit & ~done_q;

  // Array is deliberately outside reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_req && !mbox_hit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.sel_i[b]) begin
          mem_q[idx][8*b +: 8] <= bus.data_i[8*b +: 8];
        end
      end
    end
  end

  mem_rd_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (rd_req),
    .data_i  (mem_q[idx]),
    .valid_o (bus.rvalid_o),
    .data_o  (bus.data_o)
  );

  // Counter freezes at the limit; a same-cycle mailbox hit beats the timeout.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (!done_q && !timeout_q) begin
      if (wd_cnt_q == WD_LAST) begin
        if (!mbox_set) begin
          timeout_d = 1'b1;
        end
      end else begin
        wd_cnt_d = wd_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.done_o    = done_q;
  assign bus.pass_o    = pass_q;
  assign bus.timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_data_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sim_data_ram : scoreboard bench for sim_data_ram                  |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_sim_data_ram;
  import sim_mem_pkg::*;

  localparam int          ADDR_W = 4;
  localparam int          LAT    = 2;
  localparam int          TMO    = 20;
  localparam logic [31:0] MBOX   = 32'h0000_1FFC;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sim_data_ram_if bus ();

  sim_data_ram #(
    .ADDR_W         (ADDR_W),
    .RD_LATENCY     (LAT),
    .MAILBOX_ADDR   (MBOX),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Read-response scoreboard: data and arrival cycle of every rvalid pulse.
  always @(negedge clk) begin
    if (bus.rvalid_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rvalid: cyc %0d data_o %h, want no pulse", cyc, bus.data_o);
      end else begin
        mon_e = sb.pop_front();
        n_checks++;
        if (bus.data_o !== mon_e.data)
          $display("FAIL read_data: got %h, want %h", bus.data_o, mon_e.data);
        else n_pass++;
        n_checks++;
        if (cyc != mon_e.due)
          $display("FAIL read_latency: pulse at cyc %0d, want %0d", cyc, mon_e.due);
        else n_pass++;
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.data_i = d; bus.sel_i = s;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a; bus.sel_i = 4'h0;
    sb.push_back('{data: exp, due: cyc + LAT});
  endtask

  task automatic idle_wait(input int n);
    @(negedge clk);
    bus.ce_i = 1'b0; bus.we_i = 1'b0;
    for (int i = 0; i < n && sb.size() != 0; i++) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.ce_i = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.data_o !== 32'h0) $display("FAIL reset_data_o: got %h, want 0", bus.data_o); else n_pass++;
    n_checks++; if (bus.rvalid_o !== 1'b0) $display("FAIL reset_rvalid: got %b, want 0", bus.rvalid_o); else n_pass++;
    n_checks++; if (bus.done_o !== 1'b0) $display("FAIL reset_done: got %b, want 0", bus.done_o); else n_pass++;
    n_checks++; if (bus.pass_o !== 1'b0) $display("FAIL reset_pass: got %b, want 0", bus.pass_o); else n_pass++;
    n_checks++; if (bus.timeout_o !== 1'b0) $display("FAIL reset_timeout: got %b, want 0", bus.timeout_o); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_byte_lanes();
    wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    wr(32'h10, 32'h0000_00AA, 4'b0001);
    rd(32'h10, 32'hDEAD_BEAA);
    wr(32'h10, 32'h1234_5678, 4'h0);
    rd(32'h10, 32'hDEAD_BEAA);
    idle_wait(10);
    n_checks++; if (sb.size() != 0) $display("FAIL lanes_drain: %0d reads pending, want 0", sb.size()); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.data_o !== 32'hDEAD_BEAA || bus.rvalid_o !== 1'b0)
      $display("FAIL data_hold: got %h/%b, want deadbeaa/0", bus.data_o, bus.rvalid_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    wr(32'h0, 32'd1, 4'hF);
    wr(32'h4, 32'd2, 4'hF);
    wr(32'h8, 32'd3, 4'hF);
    rd(32'h0, 32'd1);
    rd(32'h4, 32'd2);
    rd(32'h8, 32'd3);
    idle_wait(10);
    n_checks++; if (sb.size() != 0) $display("FAIL b2b_drain: %0d reads pending, want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_wrap();
    wr(32'h40, 32'h0000_0055, 4'hF);
    rd(32'h00, 32'h0000_0055);
    rd(32'h03, 32'h0000_0055);
    rd(32'h44, 32'd2);
    rd(32'h10, 32'hDEAD_BEAA);
    idle_wait(10);
    n_checks++; if (sb.size() != 0) $display("FAIL wrap_drain: %0d reads pending, want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_mailbox();
    pulse_reset();
    wr(32'h3C, 32'hCAFE_F00D, 4'hF);
    wr(MBOX, 32'h0000_1234, 4'b0011);
    wr(MBOX, MBOX_PASS, 4'hF);
    n_checks++; if (bus.done_o !== 1'b0) $display("FAIL partial_not_mbox: done %b, want 0", bus.done_o); else n_pass++;
`ifdef SIM_DATA_RAM_MAILBOX_EN
    @(negedge clk);
    bus.ce_i = 1'b0;
    n_checks++; if (bus.done_o !== 1'b1) $display("FAIL mbox_done: got %b, want 1", bus.done_o); else n_pass++;
    n_checks++; if (bus.pass_o !== 1'b1) $display("FAIL mbox_pass: got %b, want 1", bus.pass_o); else n_pass++;
    wr(MBOX, MBOX_FAIL, 4'hF);
    @(negedge clk);
    bus.ce_i = 1'b0;
    n_checks++; if (bus.pass_o !== 1'b1) $display("FAIL mbox_sticky: pass %b, want 1", bus.pass_o); else n_pass++;
    rd(MBOX, 32'hCAFE_1234);
    idle_wait(10);
    repeat (30) @(negedge clk);
    n_checks++; if (bus.timeout_o !== 1'b0) $display("FAIL timeout_after_done: got %b, want 0", bus.timeout_o); else n_pass++;
`else
    @(negedge clk);
    bus.ce_i = 1'b0;
    n_checks++;
    if (bus.done_o !== 1'b0 || bus.pass_o !== 1'b0)
      $display("FAIL mbox_disabled: done/pass %b/%b, want 0/0", bus.done_o, bus.pass_o);
    else n_pass++;
    rd(MBOX, MBOX_PASS);
    rd(32'h3C, MBOX_PASS);
    idle_wait(10);
`endif
    n_checks++; if (sb.size() != 0) $display("FAIL mbox_drain: %0d reads pending, want 0", sb.size()); else n_pass++;
  endtask

  task automatic test_timeout();
    pulse_reset();
    repeat (19) @(negedge clk);
    n_checks++; if (bus.timeout_o !== 1'b0) $display("FAIL timeout_early: got %b at edge 19, want 0", bus.timeout_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.timeout_o !== 1'b1) $display("FAIL timeout_edge20: got %b, want 1", bus.timeout_o); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.timeout_o !== 1'b1) $display("FAIL timeout_sticky: got %b, want 1", bus.timeout_o); else n_pass++;
  endtask

  task automatic test_reset_midread();
    @(negedge clk);
    bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h10;
    @(negedge clk);
    bus.ce_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.data_o !== 32'h0 || bus.rvalid_o !== 1'b0 || bus.done_o !== 1'b0 ||
        bus.pass_o !== 1'b0 || bus.timeout_o !== 1'b0)
      $display("FAIL midread_reset: data/rv/done/pass/tmo %h/%b/%b/%b/%b, want all 0",
               bus.data_o, bus.rvalid_o, bus.done_o, bus.pass_o, bus.timeout_o);
    else n_pass++;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    rd(32'h10, 32'hDEAD_BEAA);
    rd(32'h00, 32'h0000_0055);
`ifdef SIM_DATA_RAM_MAILBOX_EN
    rd(32'h3C, 32'hCAFE_1234);
`else
    rd(32'h3C, MBOX_PASS);
`endif
    idle_wait(10);
    n_checks++; if (sb.size() != 0) $display("FAIL retain_drain: %0d reads pending, want 0", sb.size()); else n_pass++;
  endtask

  initial begin
    bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.sel_i = '0; bus.data_i = '0;
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_wrap();
    test_mailbox();
    test_timeout();
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
